// File: rtl/ebc_pkg.sv
// Shared types and event-word layout helpers for the event-camera readout
// sequencer. Optional wrap-marker feature: EBC_TS_WRAP_EVT_EN.
package ebc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_EMIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } ebc_state_t;

  // Event type carried in the MSB of the event word
  localparam logic EVT_PIX  = 1'b0;
  localparam logic EVT_WRAP = 1'b1;

  // Event word, MSB to LSB: type | ts | x | y
  function automatic int evt_x_lsb(input int yw);
    return yw;
  endfunction

  function automatic int evt_ts_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int evt_type_bit(input int ts_w, input int xw, input int yw);
    return ts_w + xw + yw;
  endfunction

endpackage

// File: rtl/ebc_onehot_enc.sv
// One-hot to binary encoder. A grant vector with more than one bit set is
// still encoded (lowest set bit wins) and flagged on multi_hot_o.
module ebc_onehot_enc #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] bin_o,
  output logic         any_o,
  output logic         multi_hot_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins
  always_comb begin
    bin_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot_i[i]) bin_o = W'(i);
    end
  end

  assign any_o       = |onehot_i;
  assign multi_hot_o = |(onehot_i & (onehot_i - N'(1)));

endmodule

// File: rtl/ebc_readout_ctrl.sv
// Readout sequencer for the event-camera pixel arbiter: captures row/column
// grants, stamps them with a free-running timestamp, streams them out on a
// valid/ready port, acknowledges the pixel and waits for grant release.
// Optional feature macro: EBC_TS_WRAP_EVT_EN (emit a marker on ts wrap).
module ebc_readout_ctrl
  import ebc_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int TS_W       = 16,
  parameter int TS_DIV     = 1,
  parameter int RELEASE_TO = 15,
  localparam int XW        = $clog2(ROWS),
  localparam int YW        = $clog2(COLS),
  localparam int EVT_W     = 1 + TS_W + XW + YW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [ROWS-1:0]  x_gnt_i,
  input  logic [COLS-1:0]  y_gnt_i,
  output logic             arb_enable_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [EVT_W-1:0] evt_data_o,
  output logic             pix_ack_o,
  output logic [XW-1:0]    pix_x_o,
  output logic [YW-1:0]    pix_y_o,
  output logic             err_o
);

  localparam int PW       = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int CW       = $clog2(RELEASE_TO + 1);
  localparam int TYPE_BIT = evt_type_bit(TS_W, XW, YW);
  localparam int X_LSB    = evt_x_lsb(YW);

  ebc_state_t       r_state, w_state_next;
  logic [PW-1:0]    r_presc;
  logic [TS_W-1:0]  r_ts;
  logic             w_tick;
  logic [CW-1:0]    r_rel_cnt, w_rel_cnt_next;

  logic             r_arb_en, w_arb_en_next;
  logic             r_evt_valid, w_evt_valid_next;
  logic [EVT_W-1:0] r_evt_data, w_evt_data_next;
  logic             r_pix_ack, w_pix_ack_next;
  logic [XW-1:0]    r_pix_x, w_pix_x_next;
  logic [YW-1:0]    r_pix_y, w_pix_y_next;
  logic             r_err, w_err_set;

  logic             w_wrap_pending, w_wrap_pending_next, w_wrap_err;

  logic [XW-1:0]    w_x_bin;
  logic [YW-1:0]    w_y_bin;
  logic             w_x_any, w_y_any, w_x_multi, w_y_multi;

  ebc_onehot_enc #(.N(ROWS)) u_row_enc (
    .onehot_i    (x_gnt_i),
    .bin_o       (w_x_bin),
    .any_o       (w_x_any),
    .multi_hot_o (w_x_multi)
  );

  ebc_onehot_enc #(.N(COLS)) u_col_enc (
    .onehot_i    (y_gnt_i),
    .bin_o       (w_y_bin),
    .any_o       (w_y_any),
    .multi_hot_o (w_y_multi)
  );

  assign w_tick = (r_presc == PW'(TS_DIV - 1));

  // Free-running prescaler and timestamp, independent of the FSM
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_presc <= '0;
      r_ts    <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_ts    <= r_ts + TS_W'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

`ifdef EBC_TS_WRAP_EVT_EN
  logic r_wrap_pending;
  logic w_ts_wrap;
  logic w_marker_hs;

  assign w_ts_wrap   = w_tick && (r_ts == {TS_W{1'b1}});
  assign w_marker_hs = (r_state == ST_EMIT) && evt_ready_i && r_evt_data[TYPE_BIT];

  // Pending marker: set by a wrap, cleared by marker acceptance; a wrap
  // landing on an already pending marker is an overrun
  always_comb begin
    w_wrap_pending_next = r_wrap_pending;
    w_wrap_err          = 1'b0;
    if (w_marker_hs) w_wrap_pending_next = 1'b0;
    if (w_ts_wrap) begin
      if (r_wrap_pending && !w_marker_hs) w_wrap_err = 1'b1;
      w_wrap_pending_next = 1'b1;
    end
  end

  // Wrap-pending flag register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_wrap_pending <= 1'b0;
    else         r_wrap_pending <= w_wrap_pending_next;
  end

  assign w_wrap_pending = r_wrap_pending;
`else
  assign w_wrap_pending      = 1'b0;
  assign w_wrap_pending_next = 1'b0;
  assign w_wrap_err          = 1'b0;
`endif

  // Sequencer state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and next values of every registered output. The arbiter
  // enable is computed one cycle ahead so it is itself a flop output.
  always_comb begin
    w_state_next     = r_state;
    w_arb_en_next    = 1'b0;
    w_evt_valid_next = r_evt_valid;
    w_evt_data_next  = r_evt_data;
    w_pix_ack_next   = 1'b0;
    w_pix_x_next     = r_pix_x;
    w_pix_y_next     = r_pix_y;
    w_rel_cnt_next   = '0;
    w_err_set        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_i) begin
          w_state_next  = ST_ARB;
          w_arb_en_next = !w_wrap_pending_next;
        end
      end
      ST_ARB: begin
        if (w_wrap_pending) begin
          // Marker takes precedence; grants are ignored this cycle
          w_state_next     = ST_EMIT;
          w_evt_valid_next = 1'b1;
          w_evt_data_next  = {EVT_WRAP, {(EVT_W-1){1'b0}}};
        end else if (w_x_any && w_y_any) begin
          // Keep the arbiter enabled so it holds the grant until the ack
          w_state_next     = ST_EMIT;
          w_evt_valid_next = 1'b1;
          w_evt_data_next  = {EVT_PIX, r_ts, w_x_bin, w_y_bin};
          w_arb_en_next    = 1'b1;
          w_err_set        = w_x_multi | w_y_multi;
        end else if (!enable_i) begin
          w_state_next = ST_IDLE;
        end else begin
          w_arb_en_next = !w_wrap_pending_next;
        end
      end
      ST_EMIT: begin
        w_arb_en_next = r_arb_en;
        if (evt_ready_i) begin
          w_evt_valid_next = 1'b0;
          if (r_evt_data[TYPE_BIT] == EVT_WRAP) begin
            if (enable_i) begin
              w_state_next  = ST_ARB;
              w_arb_en_next = !w_wrap_pending_next;
            end else begin
              w_state_next  = ST_IDLE;
              w_arb_en_next = 1'b0;
            end
          end else begin
            w_state_next   = ST_ACK;
            w_arb_en_next  = 1'b0;
            w_pix_ack_next = 1'b1;
            w_pix_x_next   = r_evt_data[X_LSB +: XW];
            w_pix_y_next   = r_evt_data[YW-1:0];
          end
        end
      end
      ST_ACK: begin
        w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!w_x_any && !w_y_any) begin
          if (enable_i) begin
            w_state_next  = ST_ARB;
            w_arb_en_next = !w_wrap_pending_next;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_rel_cnt == CW'(RELEASE_TO - 1)) begin
          w_err_set    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_rel_cnt_next = r_rel_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output and release-counter registers; err is sticky until reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_arb_en    <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_pix_ack   <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_err       <= 1'b0;
      r_rel_cnt   <= '0;
    end else begin
      r_arb_en    <= w_arb_en_next;
      r_evt_valid <= w_evt_valid_next;
      r_evt_data  <= w_evt_data_next;
      r_pix_ack   <= w_pix_ack_next;
      r_pix_x     <= w_pix_x_next;
      r_pix_y     <= w_pix_y_next;
      r_err       <= r_err | w_err_set | w_wrap_err;
      r_rel_cnt   <= w_rel_cnt_next;
    end
  end

  assign arb_enable_o = r_arb_en;
  assign evt_valid_o  = r_evt_valid;
  assign evt_data_o   = r_evt_data;
  assign pix_ack_o    = r_pix_ack;
  assign pix_x_o      = r_pix_x;
  assign pix_y_o      = r_pix_y;
  assign err_o        = r_err;

endmodule

// File: tb/tb_ebc_readout_ctrl.sv
// Scoreboard bench for ebc_readout_ctrl. Stimulus pushes expected event
// words and acks into queues; a monitor pops them on each handshake/ack.
// With EBC_TS_WRAP_EVT_EN defined the bench runs the wrap-marker scenario.
module tb_ebc_readout_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
`ifdef EBC_TS_WRAP_EVT_EN
  localparam int TS_W = 4;
`else
  localparam int TS_W = 16;
`endif
  localparam int TS_DIV     = 1;
  localparam int RELEASE_TO = 15;
  localparam int XW         = 3;
  localparam int YW         = 3;
  localparam int EVT_W      = 1 + TS_W + XW + YW;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             enable_i;
  logic [ROWS-1:0]  x_gnt_i;
  logic [COLS-1:0]  y_gnt_i;
  logic             arb_enable_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [EVT_W-1:0] evt_data_o;
  logic             pix_ack_o;
  logic [XW-1:0]    pix_x_o;
  logic [YW-1:0]    pix_y_o;
  logic             err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [TS_W-1:0]    tb_ts;
  logic [EVT_W-1:0]   exp_evt_q[$];
  logic [XW+YW-1:0]   exp_ack_q[$];

  ebc_readout_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .TS_W(TS_W), .TS_DIV(TS_DIV), .RELEASE_TO(RELEASE_TO)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .x_gnt_i      (x_gnt_i),
    .y_gnt_i      (y_gnt_i),
    .arb_enable_o (arb_enable_o),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_data_o   (evt_data_o),
    .pix_ack_o    (pix_ack_o),
    .pix_x_o      (pix_x_o),
    .pix_y_o      (pix_y_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference timestamp: one tick per cycle since reset release
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tb_ts <= '0;
    else         tb_ts <= tb_ts + TS_W'(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Stimulus drives and reads just after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_arb_en();
    int k = 0;
    while (arb_enable_o !== 1'b1 && k < 60) begin
      step();
      k++;
    end
    if (arb_enable_o !== 1'b1) bound_fail("arb_en_wait");
  endtask

  task automatic apply_grant(input logic [ROWS-1:0] xg, input logic [COLS-1:0] yg,
                             input logic [XW-1:0] ex, input logic [YW-1:0] ey);
    wait_arb_en();
    x_gnt_i = xg;
    y_gnt_i = yg;
    exp_evt_q.push_back({1'b0, tb_ts, ex, ey});
    exp_ack_q.push_back({ex, ey});
    step();
    chk("valid_latency", 64'(evt_valid_o), 64'd1);
  endtask

  task automatic wait_ack();
    int k = 0;
    while (pix_ack_o !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    if (pix_ack_o !== 1'b1) bound_fail("ack_wait");
  endtask

  task automatic wait_ack_release();
    wait_ack();
    x_gnt_i = '0;
    y_gnt_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arb_en"}, 64'(arb_enable_o), 64'd0);
    chk({tag, "_valid"},  64'(evt_valid_o),  64'd0);
    chk({tag, "_data"},   64'(evt_data_o),   64'd0);
    chk({tag, "_ack"},    64'(pix_ack_o),    64'd0);
    chk({tag, "_pix_x"},  64'(pix_x_o),      64'd0);
    chk({tag, "_pix_y"},  64'(pix_y_o),      64'd0);
    chk({tag, "_err"},    64'(err_o),        64'd0);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on handshakes
  logic             mon_stall   = 1'b0;
  logic             mon_hs_pix  = 1'b0;
  logic [EVT_W-1:0] mon_data    = '0;
  logic [EVT_W-1:0] mon_exp_evt;
  logic [XW+YW-1:0] mon_exp_ack;

  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i === 1'b1) begin
        mon_stall  = 1'b0;
        mon_hs_pix = 1'b0;
      end else begin
        if (mon_stall) begin
          chk("valid_hold", 64'(evt_valid_o), 64'd1);
          chk("data_hold",  64'(evt_data_o),  64'(mon_data));
        end
        if (pix_ack_o || mon_hs_pix) chk("ack_timing", 64'(pix_ack_o), 64'(mon_hs_pix));
        if (pix_ack_o) begin
          chk("ack_arb_en_low", 64'(arb_enable_o), 64'd0);
          $display("[TB] ack x=%0d y=%0d", pix_x_o, pix_y_o);
          if (exp_ack_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL ack_unexpected: actual x=%0d y=%0d required none", pix_x_o, pix_y_o);
          end else begin
            mon_exp_ack = exp_ack_q.pop_front();
            chk("ack_xy", 64'({pix_x_o, pix_y_o}), 64'(mon_exp_ack));
          end
        end
        if (evt_valid_o && evt_ready_i) begin
          $display("[TB] event data=%h", evt_data_o);
          if (exp_evt_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL evt_unexpected: actual=%h required none", evt_data_o);
          end else begin
            mon_exp_evt = exp_evt_q.pop_front();
            chk("evt_data", 64'(evt_data_o), 64'(mon_exp_evt));
          end
        end
        mon_hs_pix = evt_valid_o && evt_ready_i && !evt_data_o[EVT_W-1];
        mon_stall  = evt_valid_o && !evt_ready_i;
        mon_data   = evt_data_o;
      end
    end
  end

  initial begin
    int k;
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    evt_ready_i = 1'b1;
    x_gnt_i     = '0;
    y_gnt_i     = '0;
    repeat (3) step();
    check_all_zero("reset");
    reset_i  = 1'b0;
    enable_i = 1'b1;

`ifdef EBC_TS_WRAP_EVT_EN
    // Sit in ARB until ts wraps; the marker comes first, then the pixel
    exp_evt_q.push_back({1'b1, {(EVT_W-1){1'b0}}});
    k = 0;
    while (tb_ts != 4'd15 && k < 40) begin step(); k++; end
    step();
    chk("wrap_arb_en_low", 64'(arb_enable_o), 64'd0);
    x_gnt_i = 8'h01;
    y_gnt_i = 8'h02;
    exp_evt_q.push_back({1'b0, 4'd2, 3'd0, 3'd1});
    exp_ack_q.push_back({3'd0, 3'd1});
    wait_ack();
    enable_i = 1'b0;
    x_gnt_i  = '0;
    y_gnt_i  = '0;
    chk("wrap_no_err", 64'(err_o), 64'd0);
`else
    // Grants captured while ts=10
    k = 0;
    while (tb_ts != 16'd10 && k < 40) begin step(); k++; end
    chk("arb_en_in_arb", 64'(arb_enable_o), 64'd1);
    apply_grant(8'h04, 8'h20, 3'd2, 3'd5);
    wait_ack_release();

    // Distinct grant patterns, including both edges of the vectors
    apply_grant(8'h01, 8'h80, 3'd0, 3'd7);
    wait_ack_release();
    apply_grant(8'h80, 8'h01, 3'd7, 3'd0);
    wait_ack_release();
    apply_grant(8'h10, 8'h08, 3'd4, 3'd3);
    wait_ack_release();

    // Backpressure for 20 cycles, enable dropped mid-stall
    evt_ready_i = 1'b0;
    apply_grant(8'h02, 8'h40, 3'd1, 3'd6);
    repeat (10) step();
    enable_i = 1'b0;
    repeat (10) step();
    chk("valid_after_enable_drop", 64'(evt_valid_o), 64'd1);
    evt_ready_i = 1'b1;
    wait_ack_release();
    repeat (3) step();
    chk("idle_after_disable", 64'(arb_enable_o), 64'd0);
    enable_i = 1'b1;

    // Grants never released: timeout after RELEASE_TO cycles
    apply_grant(8'h08, 8'h10, 3'd3, 3'd4);
    wait_ack();
    repeat (15) step();
    chk("err_before_timeout", 64'(err_o), 64'd0);
    step();
    chk("err_on_timeout", 64'(err_o), 64'd1);
    chk("arb_en_on_timeout", 64'(arb_enable_o), 64'd0);
    x_gnt_i = '0;
    y_gnt_i = '0;

    // Reset while an event is stalled in EMIT
    evt_ready_i = 1'b0;
    apply_grant(8'h04, 8'h04, 3'd2, 3'd2);
    #2;
    reset_i = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_evt_q.delete();
    exp_ack_q.delete();
    x_gnt_i     = '0;
    y_gnt_i     = '0;
    enable_i    = 1'b0;
    evt_ready_i = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
    repeat (3) step();
    chk("idle_after_reset_arb_en", 64'(arb_enable_o), 64'd0);
    chk("idle_after_reset_valid",  64'(evt_valid_o),  64'd0);
    enable_i = 1'b1;

    // Multi-hot row grant: lowest bit encoded, sticky error
    apply_grant(8'h06, 8'h01, 3'd1, 3'd0);
    wait_ack_release();
    chk("err_multi_hot", 64'(err_o), 64'd1);
    apply_grant(8'h20, 8'h02, 3'd5, 3'd1);
    wait_ack_release();
    chk("err_sticky", 64'(err_o), 64'd1);
`endif

    k = 0;
    while ((exp_evt_q.size() != 0 || exp_ack_q.size() != 0) && k < 50) begin
      step();
      k++;
    end
    chk("sb_evt_drained", 64'(exp_evt_q.size()), 64'd0);
    chk("sb_ack_drained", 64'(exp_ack_q.size()), 64'd0);
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
